// File: rtl/rng_pkg.sv
// rng_pkg: shared FSM encoding and maximal-length LFSR tap masks
package rng_pkg;
    typedef enum logic [1:0] {IDLE, CALC, DONE} rng_state_e;
    function automatic logic [31:0] lfsr_taps(int w);
        case (w)
            3: return 32'h0000_0006;
            4: return 32'h0000_000C;
            5: return 32'h0000_0014;
            6: return 32'h0000_0030;
            7: return 32'h0000_0060;
            8: return 32'h0000_00B8;
            9: return 32'h0000_0110;
            10: return 32'h0000_0240;
            11: return 32'h0000_0500;
            12: return 32'h0000_0E08;
            13: return 32'h0000_1C80;
            14: return 32'h0000_3802;
            15: return 32'h0000_6000;
            16: return 32'h0000_B400;
            17: return 32'h0001_2000;
            18: return 32'h0002_0400;
            19: return 32'h0007_2000;
            20: return 32'h0009_0000;
            21: return 32'h0014_0000;
            22: return 32'h0030_0000;
            23: return 32'h0042_0000;
            24: return 32'h00E1_0000;
            25: return 32'h0120_0000;
            26: return 32'h0200_0023;
            27: return 32'h0400_0013;
            28: return 32'h0900_0000;
            29: return 32'h1400_0000;
            30: return 32'h2000_0029;
            31: return 32'h4800_0000;
            default: return 32'h8020_0003;
        endcase
    endfunction
endpackage

// File: rtl/lfsr_range_gen_if.sv
// lfsr_range_gen_if: seed/run controls, bounded-value request and results
interface lfsr_range_gen_if #(parameter int WIDTH = 16, parameter int OUT_W = 16);
    logic seed_load;
    logic [WIDTH-1:0] seed_in;
    logic run;
    logic req;
    logic [OUT_W-1:0] lo;
    logic [OUT_W-1:0] hi;
    logic busy;
    logic valid;
    logic [OUT_W-1:0] value;
    logic [WIDTH-1:0] state;
    modport master (output seed_load, seed_in, run, req, lo, hi, input busy, valid, value, state);
    modport slave (input seed_load, seed_in, run, req, lo, hi, output busy, valid, value, state);
endinterface

// File: rtl/lfsr_core.sv
// lfsr_core: Fibonacci shift-left LFSR with seed load and zero-state guard
module lfsr_core import rng_pkg::*; #(
    parameter int WIDTH = 16,
    parameter int unsigned SEED = 100
) (
    input  logic clk,
    input  logic rst,
    input  logic load,
    input  logic step,
    input  logic [WIDTH-1:0] seed_in,
    output logic [WIDTH-1:0] state
);
    localparam logic [WIDTH-1:0] TAPS = WIDTH'(lfsr_taps(WIDTH));
    localparam logic [WIDTH-1:0] SEED_W = WIDTH'(SEED);
    // load beats step; a zero seed would lock the register so SEED is substituted
    always_ff @(posedge clk or posedge rst)
        if (rst) state <= SEED_W;
        else if (load) state <= seed_in == '0 ? SEED_W : seed_in;
        else if (step) state <= {state[WIDTH-2:0], ^(state & TAPS)};
endmodule

// File: rtl/lfsr_range_gen.sv
// lfsr_range_gen: LFSR entropy source returning values bounded to [lo, hi]
module lfsr_range_gen import rng_pkg::*; #(
    parameter int WIDTH = 16,
    parameter int OUT_W = 16,
    parameter int unsigned SEED = 100
) (
    input logic clk,
    input logic rst,
    lfsr_range_gen_if.slave bus
);
    localparam int CW = $clog2(WIDTH);
    localparam logic [OUT_W:0] ONE = 1;
    if (WIDTH < 3 || WIDTH > 32 || OUT_W > WIDTH || OUT_W < 1) begin : g_bad_width
        $error("lfsr_range_gen: unsupported WIDTH/OUT_W combination");
    end
    if (SEED == 0 || (64'(SEED) >> WIDTH) != 0) begin : g_bad_seed
        $error("lfsr_range_gen: SEED must be non-zero and fit in WIDTH");
    end
    rng_state_e fsm;
    logic [WIDTH-1:0] dividend;
    logic [OUT_W-1:0] lo_q, rem, rem_next;
    logic [OUT_W:0] range_q, range_in, trial;
    logic [CW-1:0] cnt;
    logic accept;
    assign accept = bus.req && fsm == IDLE;
    assign range_in = bus.hi < bus.lo ? ONE : {1'b0, bus.hi} - {1'b0, bus.lo} + ONE;
    assign trial = {rem, dividend[cnt]};
    assign rem_next = trial >= range_q ? OUT_W'(trial - range_q) : trial[OUT_W-1:0];
    lfsr_core #(.WIDTH(WIDTH), .SEED(SEED)) u_core (
        .clk(clk),
        .rst(rst),
        .load(bus.seed_load),
        .step(bus.run | accept),
        .seed_in(bus.seed_in),
        .state(bus.state)
    );
    // capture on accept, one remainder bit per CALC cycle, publish lo+rem entering DONE
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            fsm <= IDLE;
            bus.busy <= 1'b0;
            bus.valid <= 1'b0;
            bus.value <= '0;
            dividend <= '0;
            lo_q <= '0;
            range_q <= '0;
            rem <= '0;
            cnt <= '0;
        end else begin
            case (fsm)
                IDLE: if (bus.req) begin
                    fsm <= CALC;
                    bus.busy <= 1'b1;
                    dividend <= bus.state;
                    lo_q <= bus.lo;
                    range_q <= range_in;
                    rem <= '0;
                    cnt <= CW'(WIDTH - 1);
                end
                CALC: begin
                    rem <= rem_next;
                    cnt <= cnt - 1'b1;
                    if (cnt == '0) begin
                        fsm <= DONE;
                        bus.valid <= 1'b1;
                        bus.value <= lo_q + rem_next;
                    end
                end
                DONE: begin
                    fsm <= IDLE;
                    bus.valid <= 1'b0;
                    bus.busy <= 1'b0;
                end
                default: fsm <= IDLE;
            endcase
        end
    end
endmodule

// File: doc/lfsr_range_gen.md
# lfsr_range_gen

Parametrised random-number source for the reaction-timer datapath. It provides a maximal-length Fibonacci LFSR of configurable width with runtime seed load, and a request/valid port that returns a value bounded to a runtime range [lo, hi]. The bounded value comes from a bit-serial modulo reduction. The block replaces fixed 8-bit LFSR usage wherever the game needs a bounded random delay, for example a 1000–5000 ms pre-stimulus wait.

## Interface
- WIDTH, 16: LFSR state width, 3..32.
- OUT_W, 16: width of lo/hi/value; must be ≤ WIDTH (elaboration error otherwise).
- SEED, 'd100: reset seed; must be non-zero and fit in WIDTH.
- clk  in  1  clock, all state on rising edge
- rst  in  1  reset, asynchronous, active-high
- seed_load  in  1  load seed_in into LFSR this edge
- seed_in  in  WIDTH  seed value; zero is replaced by SEED
- run  in  1  advance LFSR one step per cycle (free-running entropy)
- req  in  1  request a bounded value; accepted only when busy=0
- lo  in  OUT_W  lower bound, sampled at accept
- hi  in  OUT_W  upper bound inclusive, sampled at accept
- busy  out  1  reduction in progress
- valid  out  1  one-cycle pulse, value updated
- value  out  OUT_W  lo + (captured state mod (hi−lo+1))
- state  out  WIDTH  current LFSR state (debug/raw use)

## Operation
- LFSR: Fibonacci, shift left. New bit0 = XOR of state bits selected by TAPS(WIDTH), the maximal-length mask from the package. For WIDTH=8 the mask is 8'hB8 (bits 7,5,4,3); for WIDTH=16 it is 16'hB400.
- Step condition: run=1 OR accept of req. Two causes in the same cycle still produce one step.
- Priority per edge: seed_load > step > hold. seed_load during a step drops the step.
- Zero-state guard: loading 0 loads SEED instead. The state never becomes 0.
- FSM states: IDLE, CALC, DONE.
  - IDLE: req=1 accepts. Capture the pre-step LFSR state into the dividend register. Latch lo, and compute range = hi − lo + 1 in OUT_W+1 bits. Go to CALC with counter = WIDTH−1.
  - CALC: one restoring-division step per cycle, MSB first, producing the remainder only. After the step with counter=0, go to DONE.
  - DONE: value ← lo + remainder, valid=1 for this cycle, then return to IDLE.
- Range rules:
  - hi < lo: range is forced to 1, so value = lo.
  - lo=0 with hi=all-ones: range = 2^OUT_W, so value = state[OUT_W−1:0].
  - lo + remainder never exceeds hi, so there is no overflow.
- req while busy is ignored, not queued. lo and hi changing during CALC have no effect.
- seed_load and run remain operative during CALC. The capture is unaffected.

## Timing
- Reset values: state=SEED, FSM=IDLE, busy=0, valid=0, value=0, internal registers 0.
- Accept edge E0: busy=1 from E0.
- Division steps occur at E1..E_WIDTH. DONE is entered at E_WIDTH.
- valid=1 and value are registered for the cycle after E_WIDTH. busy=0 from E_WIDTH+1.
- Total request-to-valid latency is WIDTH+1 cycles. Back-to-back throughput is one result per WIDTH+2 cycles, since req is re-accepted in IDLE on the edge after DONE.
- value holds until the next DONE.
- LFSR step and seed load take effect one edge after the input is seen. state is a direct register output.
- rst mid-CALC: immediate abort to the reset values. No valid pulse is produced for the aborted request.

## Structure
- Package rng_pkg:
  - function lfsr_taps(int w), returning the maximal-length tap masks for 3..32;
  - FSM state enum rng_state_e {IDLE, CALC, DONE}.
- Sub-module lfsr_core (WIDTH, SEED): holds the state register, step/load priority and zero guard.
- The top holds the FSM, the capture registers and the serial remainder datapath.

## Test plan
- WIDTH=8, reset, run=1 for 2 cycles → state 100, 201, 146. Run 255 steps → state returns to 100 with no zero seen.
- WIDTH=8, state=201, run=0, req with lo=5, hi=14 → busy for 9 cycles, valid pulse with value=6 (201 mod 10 = 1). state advances to 146 at accept.
- hi=3, lo=7 → value=7. lo=0, hi=8'hFF with captured state 146 → value=146.
- seed_load with seed_in=0 → state=100. seed_load together with run → loaded value, no step.
- req during busy → ignored, exactly one valid pulse. rst asserted at cycle 4 of CALC → busy=0, valid never pulses, state=SEED.
- WIDTH=16, OUT_W=13, 1000 requests with lo=1000, hi=5000 → every value lies in [1000, 5000] and each latency is 17 cycles.
